// File: rtl/lehmer_prng_stream_if.sv
// ---------------------------------------------------------------------------
// lehmer_prng_stream_if
// Output stream of the Lehmer generator: a valid/ready handshake carrying one
// W-bit random number per transfer.
//   out_valid  master -> slave : rand_out holds a new value
//   out_ready  slave  -> master: consumer accepts rand_out this cycle
//   rand_out   master -> slave : generated number (also the generator state)
// ---------------------------------------------------------------------------
interface lehmer_prng_stream_if #(
    parameter int W = 31
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rand_out;

    modport master (
        output out_valid,
        output rand_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  rand_out,
        output out_ready
    );
endinterface

// File: rtl/lehmer_prng_stream.sv
// ---------------------------------------------------------------------------
// lehmer_prng_stream
// Lehmer generator s(n+1) = A * s(n) mod (2^W - 1). The product is formed by a
// bit-serial shift-add multiplier (one multiplier bit per cycle, MSB first)
// and reduced in a single cycle with an end-around fold, which works because
// 2^W == 1 modulo a Mersenne modulus.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   seed_load  load seed_in into the state (IDLE only); 0 and M become 1
//   seed_in    new seed
//   start      begin one generation (IDLE only)
//   cont       continuous mode, sampled when an output is accepted
//   busy       high whenever the FSM is not IDLE (registered)
//   seed_err   one-cycle pulse when a loaded seed was replaced by 1
//   out_if     master side of the rand/out_valid/out_ready stream
// ---------------------------------------------------------------------------
module lehmer_prng_stream #(
    parameter int W            = 31,
    parameter int A            = 16807,
    parameter int A_BITS       = 15,
    parameter int DEFAULT_SEED = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        seed_load,
    input  logic [W-1:0]                seed_in,
    input  logic                        start,
    input  logic                        cont,
    output logic                        busy,
    output logic                        seed_err,
    lehmer_prng_stream_if.master        out_if
);

    localparam int            AW    = W + A_BITS;
    localparam int            IW    = $clog2(A_BITS + 1);
    localparam logic [W-1:0]  M     = {W{1'b1}};
    localparam logic [A_BITS-1:0] A_VEC  = A_BITS'(A);
    localparam logic [IW-1:0]     IDX_HI = IW'(A_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FOLD,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    s_q, s_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    rand_q, rand_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            seed_err_q, seed_err_d;

    // Reduce a (W+A_BITS)-bit product modulo 2^W-1. The high part is added
    // back onto the low part (2^W == 1 mod M); the second add absorbs the
    // carry of the first and cannot itself overflow. A final conditional
    // subtract maps the alias M onto 0.
    function automatic logic [W-1:0] mersenne_fold(input logic [AW-1:0] x);
        logic [W:0]   t;
        logic [W-1:0] u;
        t = {1'b0, x[W-1:0]} + (W+1)'(x >> W);
        u = t[W-1:0] + W'(t[W]);
        if (u >= M)
            u = u - M;
        return u;
    endfunction

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        rand_d     = rand_q;
        valid_d    = valid_q;
        seed_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    if (seed_in == '0 || seed_in == M) begin
                        s_d        = W'(1);
                        seed_err_d = 1'b1;
                    end else begin
                        s_d = seed_in;
                    end
                end
                // The multiply reads s_q from the next cycle on, so a seed
                // loaded together with start is already in place.
                if (start) begin
                    state_d = S_MUL;
                    acc_d   = '0;
                    idx_d   = IDX_HI;
                end
            end

            S_MUL: begin
                acc_d = (acc_q << 1) + (A_VEC[idx_q] ? AW'(s_q) : '0);
                if (idx_q == '0)
                    state_d = S_FOLD;
                else
                    idx_d = idx_q - 1'b1;
            end

            S_FOLD: begin
                rand_d  = mersenne_fold(acc_q);
                s_d     = mersenne_fold(acc_q);
                valid_d = 1'b1;
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (valid_q && out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (cont) begin
                        state_d = S_MUL;
                        acc_d   = '0;
                        idx_d   = IDX_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            s_q        <= W'(DEFAULT_SEED);
            acc_q      <= '0;
            idx_q      <= '0;
            rand_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            rand_q     <= rand_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.rand_out  = rand_q;
    assign busy             = busy_q;
    assign seed_err         = seed_err_q;

endmodule

// File: tb/tb_lehmer_prng_stream.sv
// ---------------------------------------------------------------------------
// tb_lehmer_prng_stream
// Directed bench for lehmer_prng_stream at default parameters (W=31,
// A=16807). Expected values are hand-computed constants or come from a plain
// 64-bit multiply-and-modulo reference.
// ---------------------------------------------------------------------------
module tb_lehmer_prng_stream;

    localparam int W = 31;
    localparam logic [W-1:0] M = 31'h7FFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         seed_load;
    logic [W-1:0] seed_in;
    logic         start;
    logic         cont;
    logic         busy;
    logic         seed_err;

    int n_checks = 0;
    int n_fails  = 0;

    lehmer_prng_stream_if #(.W(W)) ifc ();

    lehmer_prng_stream #(
        .W(W), .A(16807), .A_BITS(15), .DEFAULT_SEED(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .start     (start),
        .cont      (cont),
        .busy      (busy),
        .seed_err  (seed_err),
        .out_if    (ifc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_next(input longint unsigned s);
        return (s * 64'd16807) % 64'd2147483647;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns the number of cycles waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // One single-shot generation with out_ready high, optional seed load in
    // the same cycle as start.
    task automatic gen(input logic do_load, input logic [W-1:0] sd,
                       input logic [W-1:0] exp, input string tag);
        int n;
        seed_load = do_load;
        seed_in   = sd;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        check_eq({tag, "_busy"}, busy, 1);
        wait_valid(n);
        check_eq({tag, "_latency"}, n, 16);
        check_eq({tag, "_rand"}, ifc.rand_out, exp);
        tick();
        check_eq({tag, "_valid_drop"}, ifc.out_valid, 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    // Continuous run from a loaded seed; each output compared against the
    // reference, the last also against a fixed expected value.
    task automatic run_cont(input logic [W-1:0] sd, input int count,
                            input logic [W-1:0] last_exp, input string tag);
        longint unsigned s;
        int n;
        s         = sd;
        cont      = 1'b1;
        seed_load = 1'b1;
        seed_in   = sd;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        for (int k = 0; k < count; k++) begin
            wait_valid(n);
            s = ref_next(s);
            check_eq($sformatf("%s_out%0d", tag, k), ifc.rand_out, s);
            if (k == count - 1) begin
                check_eq({tag, "_last"}, ifc.rand_out, last_exp);
                cont = 1'b0;
            end
            tick();
        end
        check_eq({tag, "_end_idle"}, busy, 0);
        check_eq({tag, "_end_valid"}, ifc.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]    held;
        int              n;
        longint unsigned s;

        rst           = 1'b1;
        seed_load     = 1'b0;
        seed_in       = '0;
        start         = 1'b0;
        cont          = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_rand", ifc.rand_out, 0);
        check_eq("rst_valid", ifc.out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_seed_err", seed_err, 0);

        // Sequence from the default seed 1.
        gen(1'b0, '0, 31'd16807, "g1");
        gen(1'b0, '0, 31'd282475249, "g2");
        gen(1'b0, '0, 31'd1622650073, "g3");

        // Ordinary seed, loaded on its own.
        seed_load = 1'b1;
        seed_in   = 31'd5;
        tick();
        seed_load = 1'b0;
        check_eq("seed5_err", seed_err, 0);
        gen(1'b0, '0, 31'd84035, "seed5");

        // Invalid seeds 0 and M are replaced by 1 with a one-cycle pulse.
        seed_load = 1'b1;
        seed_in   = '0;
        tick();
        seed_load = 1'b0;
        check_eq("seed0_err_pulse", seed_err, 1);
        tick();
        check_eq("seed0_err_clear", seed_err, 0);
        gen(1'b0, '0, 31'd16807, "seed0");

        seed_load = 1'b1;
        seed_in   = M;
        tick();
        seed_load = 1'b0;
        check_eq("seedM_err_pulse", seed_err, 1);
        tick();
        check_eq("seedM_err_clear", seed_err, 0);
        gen(1'b0, '0, 31'd16807, "seedM");

        // M-1 exercises the fold carry and the correction step.
        gen(1'b1, M - 31'd1, 31'd2147466840, "seedMm1");

        // Backpressure: seed 5 loaded with start, then 20 stalled cycles with
        // ignored load/start pulses carrying seed 7.
        ifc.out_ready = 1'b0;
        seed_load = 1'b1;
        seed_in   = 31'd5;
        start     = 1'b1;
        tick();
        seed_load = 1'b0;
        start     = 1'b0;
        wait_valid(n);
        check_eq("bp_latency", n, 16);
        check_eq("bp_rand", ifc.rand_out, 31'd84035);
        held = ifc.rand_out;
        for (int k = 0; k < 20; k++) begin
            seed_load = k[0];
            seed_in   = 31'd7;
            start     = 1'b1;
            tick();
            check_eq($sformatf("bp_valid%0d", k), ifc.out_valid, 1);
            check_eq($sformatf("bp_hold%0d", k), ifc.rand_out, held);
            check_eq($sformatf("bp_busy%0d", k), busy, 1);
            check_eq($sformatf("bp_err%0d", k), seed_err, 0);
        end
        seed_load     = 1'b0;
        start         = 1'b0;
        ifc.out_ready = 1'b1;
        tick();
        check_eq("bp_release_valid", ifc.out_valid, 0);
        check_eq("bp_release_idle", busy, 0);
        // State must still be 84035, not 7.
        gen(1'b0, '0, 31'd1412376245, "bp_next");

        // Reset in the middle of MUL discards the product and restores seed 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check_eq("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_rand", ifc.rand_out, 0);
        check_eq("mid_rst_valid", ifc.out_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_err", seed_err, 0);
        tick();
        check_eq("mid_rst_still_idle", busy, 0);
        gen(1'b0, '0, 31'd16807, "after_rst");

        // Continuous mode from seed 1.
        s = 1;
        for (int k = 0; k < 30; k++) s = ref_next(s);
        run_cont(31'd1, 30, W'(s), "cont1");

        // Continuous mode from the 9990th state: the tenth output is the
        // 10000th value of the sequence started at seed 1.
        s = 1;
        for (int k = 0; k < 9990; k++) s = ref_next(s);
        run_cont(W'(s), 10, 31'd1043618065, "cont10k");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
